// File: rtl/ks_xor_packer.sv
// Keystream consumer: steps the filter-LFSR generator WIDTH times per accepted word,
// packs the filter bits MSB-first and XORs them onto the plaintext word.
module ks_xor_packer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ks_bit,
  output logic             ks_step,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StOut     = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] ks_q, ks_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic in_xfer, out_xfer;

  // Outputs decode from registered state only; din_ready is additionally gated by reset.
  assign ks_step    = (state_q == StCollect);
  assign dout_valid = (state_q == StOut);
  assign busy       = (state_q != StIdle);
  assign din_ready  = rst_n && (state_q == StIdle);
  assign dout       = data_q ^ ks_q;

  assign in_xfer  = din_valid && (state_q == StIdle);
  assign out_xfer = dout_ready && (state_q == StOut);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ks_d    = ks_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          data_d  = din;
          ks_d    = '0;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        // First sampled bit walks up to the MSB after WIDTH shifts.
        ks_d  = {ks_q[WIDTH-2:0], ks_bit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      ks_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ks_q    <= ks_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ks_xor_packer.sv
// Bench for ks_xor_packer: directed table, random words against a word-level model,
// back-to-back, backpressure and mid-word reset with a filter-LFSR generator attached.
module tb_ks_xor_packer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ks_bit;
  logic         ks_step;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;

  logic         use_gen;
  logic         pat_bit;
  logic         gen_load;
  logic [15:0]  gen_q;
  logic [15:0]  m_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ks_xor_packer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ks_bit     (ks_bit),
    .ks_step    (ks_step),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic filt(input logic [15:0] s);
    return s[0] ^ s[5] ^ (s[3] & s[9]) ^ (s[7] & s[12] & s[14]);
  endfunction

  // Stand-in generator: shifts only on edges where ks_step is sampled high.
  always @(posedge clk) begin
    if (gen_load) gen_q <= 16'hACE1;
    else if (ks_step) gen_q <= lfsr_next(gen_q);
  end

  assign ks_bit = use_gen ? filt(gen_q) : pat_bit;

  task automatic model_take(output logic [W-1:0] w);
    w = '0;
    for (int i = 0; i < W; i++) begin
      w = {w[W-2:0], filt(m_state)};
      m_state = lfsr_next(m_state);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full word: accept, collect (pattern MSB first), optional hold, drain.
  task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] pat,
                          input logic [W-1:0] exp, input int hold, input string name);
    int steps, lat, bad;
    bit got;
    steps = 0; lat = 0; bad = 0; got = 0;
    @(posedge clk); #1;
    din = d; din_valid = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    check({name, " din_ready"}, 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = W'($urandom);
    for (int c = 0; c < W + 6 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (dout_valid) got = 1;
      else if (ks_step) begin
        if (steps < W) pat_bit = pat[W-1-steps];
        steps++;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(W + 1));
    check({name, " steps"}, 32'(steps), 32'(W));
    check({name, " dout"}, 32'(dout), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      din_valid = 1'($urandom);
      din = W'($urandom);
      @(negedge clk);
      if (dout !== exp || dout_valid !== 1'b1 || ks_step !== 1'b0 || din_ready !== 1'b0) bad++;
    end
    if (hold > 0) check({name, " hold"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    check({name, " valid before xfer"}, 32'(dout_valid), 32'd1);
    @(posedge clk); #1;
    dout_ready = 1'($urandom);
    @(negedge clk);
    check({name, " post xfer"}, {dout, 5'(0), dout_valid, din_ready, ks_step, busy},
          {exp, 5'(0), 1'b0, 1'b1, 1'b0, 1'b0});
    dout_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] pat;
    logic [W-1:0] exp;
    int           hold;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [W-1:0] d, p, w;
    int cyc, ksn, na, no, steps, bad;
    int acc_cyc[4];
    logic [W-1:0] outs[4];
    bit acc;

    tbl[0] = '{8'h00, 8'hB2, 8'hB2, 0};
    tbl[1] = '{8'h5A, 8'hFF, 8'hA5, 0};
    tbl[2] = '{8'h5A, 8'h00, 8'h5A, 0};
    tbl[3] = '{8'hC3, 8'h3C, 8'hFF, 10};
    tbl[4] = '{8'hFF, 8'h81, 8'h7E, 2};

    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    use_gen = 1'b0; pat_bit = 1'b0; gen_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("din_ready gated in reset", 32'(din_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; gen_load = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({din_ready, dout_valid, ks_step, busy} !== 4'b1000 || dout !== '0) bad++;
    end
    check("idle after reset", 32'(bad), 32'd0);

    for (int i = 0; i < 5; i++) run_word(tbl[i].din, tbl[i].pat, tbl[i].exp, tbl[i].hold,
                                         $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      p = W'($urandom);
      run_word(d, p, d ^ p, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Back-to-back with din_valid held high and dout_ready held high.
    @(posedge clk); #1;
    din = 8'h11; din_valid = 1'b1; dout_ready = 1'b1; pat_bit = 1'b1;
    cyc = 0; ksn = 0; na = 0; no = 0;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      cyc++;
      if (ks_step) ksn++;
      if (dout_valid && dout_ready && no < 4) begin outs[no] = dout; no++; end
      acc = din_valid && din_ready;
      if (acc && na < 4) begin acc_cyc[na] = cyc; na++; end
      @(posedge clk); #1;
      if (acc && na == 1) din = 8'h22;
      if (acc && na == 2) din_valid = 1'b0;
    end
    check("b2b accepts", 32'(na), 32'd2);
    check("b2b spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
    check("b2b ks_step count", 32'(ksn), 32'(2 * W));
    check("b2b out count", 32'(no), 32'd2);
    check("b2b word0", 32'(outs[0]), 32'h00EE);
    check("b2b word1", 32'(outs[1]), 32'h00DD);
    dout_ready = 1'b0; din_valid = 1'b0;

    // Real generator, reloaded from its seed between words only via its own register.
    @(posedge clk); #1;
    gen_load = 1'b1;
    @(posedge clk); #1;
    gen_load = 1'b0; use_gen = 1'b1;
    m_state = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      d = W'($urandom);
      model_take(w);
      run_word(d, '0, d ^ w, i, $sformatf("gen%0d", i));
    end

    // Reset while collecting: bit 3 edge still steps the generator, nothing is rewound.
    @(posedge clk); #1;
    din = 8'h3C; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    steps = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (ks_step) begin
        if (steps == 3) begin rst_n = 1'b0; break; end
        steps++;
      end
    end
    check("reset point reached", 32'(steps), 32'd3);
    @(negedge clk);
    check("in reset", {din_ready, dout_valid, ks_step, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset", {din_ready, dout_valid, ks_step, busy}, 32'h8);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dout_valid || ks_step) bad++;
    end
    check("no pulse after reset", 32'(bad), 32'd0);
    for (int i = 0; i < 4; i++) m_state = lfsr_next(m_state);
    d = 8'h96;
    model_take(w);
    run_word(d, '0, d ^ w, 1, "gen after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ks_xor_packer.md
# ks_xor_packer

Keystream consumer stage placed directly downstream of the nonlinear-filter LFSR keystream generator. It drives the generator's step-enable, collects `WIDTH` consecutive filter-output bits into a keystream word and XORs that word with an accepted plaintext word. The result is presented on a valid/ready output port. One word is processed at a time, and the generator advances only while a word is being collected, so no keystream bit is skipped or reused.

## Interface
- `WIDTH`, default 8: bits per data/keystream word; legal range 2..16.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `ks_bit`  in  1: current filter output of the keystream generator.
- `ks_step`  out  1: step-enable to the generator. When sampled high at a rising edge, the generator shifts once at that edge.
- `din`  in  `WIDTH`: plaintext word.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: block can accept `din`. A transfer occurs when `din_valid` and `din_ready` are both high at a rising edge.
- `dout`  out  `WIDTH`: ciphertext word, `din` XOR keystream word.
- `dout_valid`  out  1: `dout` is valid.
- `dout_ready`  in  1: downstream accepts `dout`. A transfer occurs when `dout_valid` and `dout_ready` are both high at a rising edge.
- `busy`  out  1: high in COLLECT or OUT.

## Operation
- FSM states: IDLE, COLLECT, OUT.
- Registers: state, `data_q[WIDTH-1:0]`, `ks_q[WIDTH-1:0]`, bit counter `cnt` of width clog2(`WIDTH`).
- Reset (`rst_n` low at an edge) sets:
  - state = IDLE; `data_q`, `ks_q` and `cnt` = 0.
  - Outputs after reset: `dout` = 0, `dout_valid` = 0, `ks_step` = 0, `busy` = 0, `din_ready` = 1.
  - `din_ready` is gated with `rst_n`, so it reads 0 while `rst_n` is low.
- IDLE:
  - `din_ready` = 1.
  - On an input transfer: `data_q` <= `din`, `ks_q` <= 0, `cnt` <= 0, go to COLLECT.
  - Otherwise stay in IDLE.
- COLLECT:
  - `ks_step` = 1 and `din_ready` = 0.
  - Each edge: `ks_q` <= {`ks_q[WIDTH-2:0]`, `ks_bit`} and `cnt` <= `cnt`+1.
  - On the edge where `cnt` == `WIDTH`-1, go to OUT.
  - The first collected bit ends up in the MSB of `ks_q`.
- OUT:
  - `dout_valid` = 1 and `dout` = `data_q` ^ `ks_q`.
  - `dout` is stable while `dout_valid` is high and `dout_ready` is low.
  - On an output transfer, go to IDLE.
  - `dout` keeps its last value after the transfer. Only `dout_valid` drops.
- `ks_step` is a pure decode of state == COLLECT. It is never high in IDLE or OUT, so the generator holds its state between words.
- Bit accounting: exactly `WIDTH` generator steps per word. The bit sampled at each COLLECT edge is the pre-shift filter output for that same edge.
- Reset mid-COLLECT or mid-OUT:
  - The word is discarded and the FSM returns to IDLE; no `dout_valid` pulse occurs.
  - Generator steps already taken are not rewound.
- `din_valid` or `din` toggling outside IDLE is ignored.
- `dout_ready` outside OUT is ignored.

## Timing
- Input transfer at edge n. COLLECT occupies cycles n+1..n+`WIDTH`. Keystream bits are sampled at edges n+1..n+`WIDTH`.
- `dout_valid` rises after edge n+`WIDTH`. Latency from accept to valid is `WIDTH` cycles.
- With `dout_ready` held high:
  - The output transfer happens at edge n+`WIDTH`+1.
  - `din_ready` is high again in the following cycle.
  - The next input transfer is possible at edge n+`WIDTH`+2.
  - Peak throughput is one word per `WIDTH`+2 cycles.
- No combinational path from `dout_ready` or `din_valid` to any output. All outputs decode from registered state, except `din_ready`, which also depends on `rst_n`.

## Test plan
- Reset, then idle: check `din_valid` = 0 for 5 cycles -> `din_ready` = 1, `dout_valid` = 0, `ks_step` = 0, `dout` = 0, `busy` = 0.
- `WIDTH` = 8, `ks_bit` driven 1,0,1,1,0,0,1,0 on the 8 COLLECT edges, `din` = 0x00 -> `dout` = 0xB2. `ks_step` is high for exactly 8 cycles, and `dout_valid` is high 8 cycles after the accept edge.
- `ks_bit` held 1, `din` = 0x5A -> `dout` = 0xA5. Repeat with `ks_bit` held 0 and `din` = 0x5A -> `dout` = 0x5A.
- Backpressure: `dout_ready` held 0 for 10 cycles in OUT -> `dout` stable, `dout_valid` high, `ks_step` 0, `din_ready` 0, and a `din_valid` pulse is not accepted. Releasing `dout_ready` completes the transfer in 1 cycle.
- Back-to-back: `din_valid` held high with `din` 0x11 then 0x22, `dout_ready` held 1 -> accepts spaced 10 cycles apart, 16 total `ks_step` cycles, and two distinct output transfers.
- Connected to the real generator (INIT 0xACE1): the block's outputs match a reference-model keystream for 4 consecutive words. Asserting `rst_n` low at COLLECT bit 3 -> no `dout_valid` pulse, FSM in IDLE, and `din_ready` = 1 on the cycle after `rst_n` returns high.
